// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: assembles big-endian 16-bit words,
// writes them at consecutive addresses and verifies a trailing 16-bit checksum.
module imem_loader #(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              csum_err
);

  // Handshake: a byte moves on a rising clk edge where in_valid & in_ready are both high;
  // in_ready depends only on the registered state, and the source holds in_data until then.
  typedef enum logic [2:0] {
    S_IDLE, S_HI, S_LO, S_WR, S_CK_HI, S_CK_LO, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, len_q, count_q;
  logic [15:0]       word_q, sum_q;
  logic [7:0]        hi_q;
  logic              csum_err_q;
  logic              xfer;
  logic              last_word;

  assign xfer      = in_valid & in_ready;
  // len==0 makes len-1 all ones, so the loop runs the full 2^ADDR_W words.
  assign last_word = (count_q == (len_q - ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_HI;
      S_HI:    if (xfer)  state_nxt = S_LO;
      S_LO:    if (xfer)  state_nxt = S_WR;
      S_WR:    state_nxt = last_word ? S_CK_HI : S_HI;
      S_CK_HI: if (xfer)  state_nxt = S_CK_LO;
      S_CK_LO: if (xfer)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    done     = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_HI, S_LO, S_CK_HI, S_CK_LO: in_ready = 1'b1;
      S_WR:                         wr_en    = 1'b1;
      S_DONE:                       done     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      len_q      <= '0;
      count_q    <= '0;
      word_q     <= '0;
      sum_q      <= '0;
      hi_q       <= '0;
      csum_err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          len_q      <= len;
          addr_q     <= BASE_ADDR;
          sum_q      <= '0;
          count_q    <= '0;
          csum_err_q <= 1'b0;
        end
        S_HI, S_CK_HI: if (xfer) hi_q <= in_data;
        S_LO:          if (xfer) word_q <= {hi_q, in_data};
        S_WR: begin
          sum_q   <= sum_q + word_q;
          addr_q  <= addr_q + ONE;
          count_q <= count_q + ONE;
        end
        // The checksum word is compared on the fly and never stored.
        S_CK_LO: if (xfer) csum_err_q <= ({hi_q, in_data} != sum_q);
        default: ;
      endcase
    end
  end

  assign wr_addr  = addr_q;
  assign wr_data  = word_q;
  assign csum_err = csum_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (base 0x000 and 0xFFF) share one stimulus
// stream; writes are scored against an expected queue built from the words sent.
module tb_imem_loader;

  localparam int AW = 12;

  logic          clk, rst, start, in_valid;
  logic [AW-1:0] len;
  logic [7:0]    in_data;
  logic          in_ready, wr_en, busy, done, csum_err;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          in_ready_w, wr_en_w, busy_w, done_w, csum_err_w;
  logic [AW-1:0] wr_addr_w;
  logic [15:0]   wr_data_w;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt, hs_cnt, done_cnt;
  logic [AW-1:0]      addr_model;
  logic [AW+16-1:0]   exp_q[$];
  logic [15:0]        wq[$];

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(12'h000)) u_dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .csum_err(csum_err)
  );

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(12'hFFF)) u_dut_w (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_w), .wr_en(wr_en_w), .wr_addr(wr_addr_w), .wr_data(wr_data_w),
    .busy(busy_w), .done(done_w), .csum_err(csum_err_w)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe pops one expected {addr,data}
  always @(negedge clk) begin
    if (in_valid && in_ready) hs_cnt++;
    if (done) done_cnt++;
    if (wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'({wr_addr, wr_data}), 32'hFFFF_FFFF);
      end else begin
        check("wr_addr_data", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
      end
      check("wr_base_fff", 32'({wr_en_w, wr_addr_w, wr_data_w}),
            32'({1'b1, wr_addr + 12'hFFF, wr_data}));
    end
  end

  // Driver tasks; all drives happen 1ns after a rising edge
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int waited;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic do_start(input logic [AW-1:0] l);
    wr_cnt     = 0;
    hs_cnt     = 0;
    done_cnt   = 0;
    addr_model = '0;
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
    len   = 12'h5A5;
    check("start_in_ready", 32'(in_ready), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_csum_clear", 32'(csum_err), 32'd0);
  endtask

  task automatic run_load(input string tag, input logic [AW-1:0] l, input logic [15:0] csum,
                          input logic exp_err, input int max_gap, input logic stray_start);
    int n;
    n = wq.size();
    do_start(l);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({addr_model, wq[i]});
      if (stray_start && i == 0) begin
        start = 1'b1;
        len   = 12'd7;
      end
      send_byte(wq[i][15:8], max_gap);
      start = 1'b0;
      send_byte(wq[i][7:0], max_gap);
      if (i < 4) check({tag, "_wr_latency"}, 32'(wr_en), 32'd1);
      addr_model = addr_model + 12'd1;
    end
    send_byte(csum[15:8], max_gap);
    send_byte(csum[7:0], max_gap);
    check({tag, "_done_pulse"}, 32'({done, busy, in_ready}), 32'b110);
    @(posedge clk); #1;
    check({tag, "_after_done"}, 32'({done, busy}), 32'b00);
    check({tag, "_csum_err"}, 32'(csum_err), 32'(exp_err));
    check({tag, "_base_fff_flags"}, 32'({csum_err_w, busy_w, done_w, in_ready_w}),
          32'({exp_err, 3'b000}));
    check({tag, "_exp_q_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_wr_count"}, 32'(wr_cnt), 32'(n));
    check({tag, "_byte_count"}, 32'(hs_cnt), 32'(2 * n + 2));
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; len = '0;
    wr_cnt = 0; hs_cnt = 0; done_cnt = 0; addr_model = '0;
    #1;
    check("reset_outputs", 32'({in_ready, wr_en, busy, done, csum_err, wr_addr, wr_data}), 32'd0);
    #12 rst = 1'b0;
    @(posedge clk); #1;
    check("idle_outputs", 32'({in_ready, wr_en, busy, done, csum_err}), 32'd0);

    // 1: two words, correct checksum, back-to-back bytes
    wq = '{16'h6011, 16'h6242};
    run_load("t1", 12'd2, 16'hC253, 1'b0, 0, 1'b0);

    // 2: bad checksum -> sticky error until the next start
    run_load("t2", 12'd2, 16'h0000, 1'b1, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t2_csum_sticky", 32'(csum_err), 32'd1);

    // 3: random valid gaps with data noise while nothing is accepted
    run_load("t3", 12'd2, 16'hC253, 1'b0, 3, 1'b0);

    // 4: address wrap on the 0xFFF-based instance and 16-bit sum wrap
    wq = '{16'hFFFF, 16'h0002};
    run_load("t4", 12'd2, 16'h0001, 1'b0, 0, 1'b0);

    // 6: start pulsed during HI is ignored
    wq = '{16'h6011, 16'h6242};
    run_load("t6", 12'd2, 16'hC253, 1'b0, 0, 1'b1);

    // 5: async reset after the first word's write, then a clean one-word load
    do_start(12'd2);
    exp_q.push_back({12'h000, 16'h6011});
    send_byte(8'h60, 0);
    send_byte(8'h11, 0);
    @(posedge clk); #1;
    check("t5_in_hi", 32'({in_ready, busy}), 32'b11);
    #2 rst = 1'b1;
    #1;
    check("t5_async_reset", 32'({in_ready, wr_en, busy, done, wr_addr}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_first_word_written", 32'(wr_cnt), 32'd1);
    wq = '{16'h6000};
    run_load("t5", 12'd1, 16'h6000, 1'b0, 0, 1'b0);

    // len==0 loads the whole 4096-word space
    wq.delete();
    for (int i = 0; i < 4096; i++) wq.push_back(16'h0001);
    run_load("len0", 12'd0, 16'h1000, 1'b0, 0, 1'b0);
    check("len0_addr_wrapped", 32'(addr_model), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer-side counterpart of the CPU's instruction memory: takes a byte stream over a valid/ready handshake, assembles 16-bit instruction words (high byte first), and writes them into the instruction memory's write port at consecutive addresses. A trailing 16-bit checksum word is received and compared against the running sum of the loaded words. `busy` holds the CPU off the memory while a load is in progress.

Parameters:
- ADDR_W, 12, instruction memory address width (memory depth = 2^ADDR_W words).
- BASE_ADDR, 0, first write address of every load.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- len  in  ADDR_W  number of instruction words to load; sampled with start; value 0 means 2^ADDR_W words.
- in_valid  in  1  in_data holds a valid byte.
- in_data  in  8  byte stream; instruction high byte first, then low byte.
- in_ready  out  1  loader accepts a byte this cycle; a byte transfers when in_valid & in_ready at a clock edge.
- wr_en  out  1  instruction memory write strobe, 1 cycle per word.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  16  instruction word written.
- busy  out  1  load in progress; the CPU is held while this is high.
- done  out  1  one-cycle pulse at the end of a load.
- csum_err  out  1  checksum mismatch on the last load; sticky until the next accepted start.

Behaviour:
- Reset (async): state=IDLE. in_ready, wr_en, busy, done, csum_err = 0. wr_addr = 0, wr_data = 0. Internal sum, count and byte latch = 0.
- Registered outputs: all outputs are decoded from registered state.
- States: IDLE, HI, LO, WR, CK_HI, CK_LO, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1: latch len; addr=BASE_ADDR; sum=0; count=0; csum_err=0 → HI.
  - in_ready rises on the cycle after start.
- HI: in_ready=1; on handshake latch the high byte → LO.
- LO: in_ready=1; on handshake word={hi,in_data} → WR.
- WR:
  - in_ready=0; wr_en=1 for exactly this cycle, with wr_addr=addr and wr_data=word.
  - Latency: last-byte handshake edge N → wr_en high during cycle N+1.
  - Updates at end of WR:
    - sum = (sum+word) mod 2^16.
    - addr = (addr+1) mod 2^ADDR_W; wraps 2^ADDR_W-1 → 0.
    - count++.
  - Next state: if count (pre-increment) == len-1 mod 2^ADDR_W → CK_HI, else → HI.
- CK_HI / CK_LO: same handshake as HI/LO; assemble the checksum word; no write. On the CK_LO handshake, csum_err <= (checksum != sum) → DONE.
- DONE: done=1 for one cycle, in_ready=0, busy=1 → IDLE. busy falls the cycle after done.
- busy=1 in every state except IDLE.
- wr_en is never asserted outside WR.
- start while not IDLE is ignored.
- in_valid with in_ready=0: nothing is consumed; the source must hold in_data until the handshake.
- Gaps in in_valid stall the FSM in its current state with no side effects.
- Async reset mid-load: immediate return to IDLE with all outputs 0. Words already written stay in memory. A new start after reset behaves normally.
- len=0 loads 2^ADDR_W words, then the checksum.

Test Plan:
1. BASE_ADDR=0, len=2, bytes 60 11 62 42 C2 53 with in_valid continuously high → wr (0,0x6011), (1,0x6242); done pulse; csum_err=0; busy low the cycle after done.
2. Same words, checksum bytes 00 00 → both writes occur, done pulses, csum_err=1 and stays 1 until the next start (which clears it).
3. Scenario 1 with random 0–3 cycle in_valid gaps and in_data toggling while in_ready=0 → identical writes, exactly 2 wr_en pulses, no extra byte consumed.
4. BASE_ADDR=0xFFF, len=2, words FFFF and 0002, checksum 0001 → writes at 0xFFF then 0x000; sum wraps to 0x0001; csum_err=0.
5. Assert rst asynchronously between clock edges after the first word's WR → wr_en, busy, in_ready drop to 0 immediately. Then start with len=1, word 6000, checksum 6000 → write (0,0x6000), csum_err=0.
6. Pulse start while in HI → ignored: len and addr unchanged, load completes as originally programmed.
